// File: rtl/axi_stream_strip_header_if.sv
// Bundles the ingress, payload and header channels of axi_stream_strip_header.
// The design is the slave side; the traffic source and sinks use the master side.
interface axi_stream_strip_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_hdr;
  logic [DATA_WD-1:0]      data_hdr;
  logic [DATA_BYTE_WD-1:0] keep_hdr;
  logic                    ready_hdr;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, byte_strip_cnt, ready_out, ready_hdr,
    output ready_in, valid_out, data_out, keep_out, last_out, valid_hdr, data_hdr, keep_hdr
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, byte_strip_cnt, ready_out, ready_hdr,
    input  ready_in, valid_out, data_out, keep_out, last_out, valid_hdr, data_hdr, keep_hdr
  );
endinterface

// File: rtl/axi_stream_strip_header.sv
// Strips N leading header bytes from an AXI-Stream packet and re-aligns the payload.
// Define STRIP_HDR_OUT_EN to expose the stripped bytes on the header channel.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input logic                     clk,
  input logic                     rst_n,
  axi_stream_strip_header_if.slave bus
);

  localparam logic [BYTE_CNT_WD-1:0] W_CNT = BYTE_CNT_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  n_q, n_in, n_cur, hi_n;
  logic [DATA_WD-1:0]      din_m, lo_data, hi_data, res_q;
  logic [DATA_BYTE_WD-1:0] lo_keep, hi_keep, res_keep_q;
  logic                    rdy, slot_free, hdr_free;
  logic                    first_load, res_load, out_load;
  logic [DATA_WD-1:0]      out_data_q, out_data_d;
  logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
  logic                    out_valid_q, out_last_q, out_last_d;

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Residual is kept MSB-aligned (data and keep) so the merge is a plain OR and
  // the TAIL beat is the residual itself; invalid payload lanes are zeroed.
  always_comb begin
    n_in    = (bus.byte_strip_cnt > W_CNT) ? W_CNT : bus.byte_strip_cnt;
    n_cur   = (state_q == IDLE) ? n_in : n_q;
    hi_n    = W_CNT - n_cur;
    din_m   = bus.data_in & byte_mask(bus.keep_in);
    lo_data = din_m << {n_cur, 3'b000};
    lo_keep = bus.keep_in << n_cur;
    hi_data = din_m >> {hi_n, 3'b000};
    hi_keep = bus.keep_in >> hi_n;
  end

  assign slot_free = !out_valid_q || bus.ready_out;

  always_comb begin
    state_d    = state_q;
    rdy        = 1'b0;
    first_load = 1'b0;
    res_load   = 1'b0;
    out_load   = 1'b0;
    out_data_d = res_q | hi_data;
    out_keep_d = res_keep_q | hi_keep;
    out_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = hdr_free && slot_free;
        if (bus.valid_in && rdy) begin
          first_load = 1'b1;
          res_load   = 1'b1;
          if (bus.last_in) begin
            // k <= N leaves lo_keep/lo_data empty: a zero-byte last beat keeps framing
            out_load   = 1'b1;
            out_data_d = lo_data;
            out_keep_d = lo_keep;
            out_last_d = 1'b1;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        rdy = slot_free;
        if (bus.valid_in && rdy) begin
          out_load = 1'b1;
          res_load = 1'b1;
          if (bus.last_in) begin
            if (lo_keep != '0) begin
              state_d = TAIL;
            end else begin
              out_last_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          out_load   = 1'b1;
          out_data_d = res_q;
          out_keep_d = res_keep_q;
          out_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      res_q      <= '0;
      res_keep_q <= '0;
    end else begin
      state_q <= state_d;
      if (first_load) n_q <= n_in;
      if (res_load) begin
        res_q      <= lo_data;
        res_keep_q <= lo_keep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end else if (bus.ready_out) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.ready_in  = rdy && rst_n;
  assign bus.valid_out = out_valid_q;
  assign bus.data_out  = out_data_q;
  assign bus.keep_out  = out_keep_q;
  assign bus.last_out  = out_last_q;

`ifdef STRIP_HDR_OUT_EN
  logic                    hdr_valid_q;
  logic [DATA_WD-1:0]      hdr_data_q;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q;

  // A first beat is only accepted with the header register empty, so load and pop never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
    end else if (first_load) begin
      hdr_valid_q <= 1'b1;
      hdr_data_q  <= bus.data_in >> {hi_n, 3'b000};
      hdr_keep_q  <= ~({DATA_BYTE_WD{1'b1}} << n_cur);
    end else if (bus.ready_hdr) begin
      hdr_valid_q <= 1'b0;
    end
  end

  assign hdr_free     = !hdr_valid_q;
  assign bus.valid_hdr = hdr_valid_q;
  assign bus.data_hdr  = hdr_data_q;
  assign bus.keep_hdr  = hdr_keep_q;
`else
  logic unused_ready_hdr;

  assign unused_ready_hdr = bus.ready_hdr;
  assign hdr_free         = 1'b1;
  assign bus.valid_hdr    = 1'b0;
  assign bus.data_hdr     = '0;
  assign bus.keep_hdr     = '0;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: directed packets push expected beats,
// a negedge monitor pops and compares payload/header beats and checks stall stability.
module tb_axi_stream_strip_header;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_stream_strip_header_if #(.DATA_WD(32)) bus();

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       pq[$];
  beat_t       hq[$];
  beat_t       e_beat, held;
  logic        stall_prev = 1'b0;
  int unsigned checks = 0, errors = 0;
  int unsigned cyc = 0, accept_cyc = 0, pop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, want);
    end
  endtask

  task automatic ep(input logic [31:0] d, input logic [3:0] k, input logic l);
    pq.push_back({d, k, l});
  endtask

  task automatic eh(input logic [31:0] d, input logic [3:0] k);
`ifdef STRIP_HDR_OUT_EN
    hq.push_back({d, k, 1'b0});
`else
    if (d === 32'hx && k === 4'hx) $display("unreachable");
`endif
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", {63'd0, bus.valid_out}, 64'd1);
        chk("hold_beat", {27'd0, bus.data_out, bus.keep_out, bus.last_out}, {27'd0, held});
      end
      if (bus.valid_out && !bus.ready_out) begin
        chk("stall_ready_in", {63'd0, bus.ready_in}, 64'd0);
        held       = {bus.data_out, bus.keep_out, bus.last_out};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.valid_out && bus.ready_out) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL payload_unexpected got %h/%h/%b exp none", bus.data_out, bus.keep_out, bus.last_out);
        end else begin
          e_beat = pq.pop_front();
          chk("payload", {27'd0, bus.data_out, bus.keep_out, bus.last_out}, {27'd0, e_beat});
        end
      end
`ifdef STRIP_HDR_OUT_EN
      if (bus.valid_hdr && bus.ready_hdr) begin
        if (hq.size() == 0) begin
          checks++; errors++;
          $display("FAIL header_unexpected got %h/%h exp none", bus.data_hdr, bus.keep_hdr);
        end else begin
          e_beat = hq.pop_front();
          chk("header", {27'd0, bus.data_hdr, bus.keep_hdr, 1'b0}, {27'd0, e_beat});
        end
      end
`endif
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [2:0] n);
    int unsigned w = 0;
    bus.valid_in = 1'b1; bus.data_in = d; bus.keep_in = k; bus.last_in = l; bus.byte_strip_cnt = n;
    @(negedge clk);
    while (!bus.ready_in && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", {63'd0, bus.ready_in}, 64'd1);
    @(posedge clk);
    #1;
    accept_cyc   = cyc;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  // Caller is positioned just after a rising edge (or at time 0).
  task automatic reset_check();
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_payload", {26'd0, bus.valid_out, bus.data_out, bus.keep_out, bus.last_out, bus.ready_in}, 64'd0);
      chk("rst_header", {27'd0, bus.valid_hdr, bus.data_hdr, bus.keep_hdr}, 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, bus.ready_in}, 64'd1);
  endtask

  task automatic drain();
    int unsigned w = 0;
    while ((pq.size() != 0 || hq.size() != 0) && w < 200) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    chk("drain_payload", 64'(pq.size()), 64'd0);
    chk("drain_header", 64'(hq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.byte_strip_cnt = '0; bus.ready_out = 1'b1; bus.ready_hdr = 1'b1;
    reset_check();
    @(posedge clk); #1;

    // N=1, three beats, TAIL path
    eh(32'h000000AA, 4'b0001);
    ep(32'hBBCCDD11, 4'b1111, 1'b0);
    ep(32'h22334455, 4'b1111, 1'b0);
    ep(32'h66000000, 4'b1000, 1'b1);
    send(32'hAABBCCDD, 4'b1111, 1'b0, 3'd1);
    send(32'h11223344, 4'b1111, 1'b0, 3'd1);
    send(32'h55660000, 4'b1100, 1'b1, 3'd1);
    drain();

    // N=3, same packet, no TAIL
    eh(32'h00AABBCC, 4'b0111);
    ep(32'hDD112233, 4'b1111, 1'b0);
    ep(32'h44556600, 4'b1110, 1'b1);
    send(32'hAABBCCDD, 4'b1111, 1'b0, 3'd3);
    send(32'h11223344, 4'b1111, 1'b0, 3'd3);
    send(32'h55660000, 4'b1100, 1'b1, 3'd3);
    drain();

    // N=4 single beat: empty last payload beat
    eh(32'h01020304, 4'b1111);
    ep(32'h00000000, 4'b0000, 1'b1);
    send(32'h01020304, 4'b1111, 1'b1, 3'd4);
    drain();

    // N=7 clamps to 4
    eh(32'hCAFEBABE, 4'b1111);
    ep(32'h00000000, 4'b0000, 1'b1);
    send(32'hCAFEBABE, 4'b1111, 1'b1, 3'd7);
    drain();

    // N=2 with ready_out low for three cycles mid-packet
    eh(32'h0000A1A2, 4'b0011);
    ep(32'hA3A4B1B2, 4'b1111, 1'b0);
    ep(32'hB3B4C1C2, 4'b1111, 1'b0);
    ep(32'hC3C4D1D2, 4'b1111, 1'b1);
    fork
      begin
        send(32'hA1A2A3A4, 4'b1111, 1'b0, 3'd2);
        send(32'hB1B2B3B4, 4'b1111, 1'b0, 3'd2);
        send(32'hC1C2C3C4, 4'b1111, 1'b0, 3'd2);
        send(32'hD1D20000, 4'b1100, 1'b1, 3'd2);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.ready_out = 1'b1;
      end
    join
    drain();

`ifdef STRIP_HDR_OUT_EN
    // header held: next first beat waits for the pop
    bus.ready_hdr = 1'b0;
    eh(32'h00000011, 4'b0001);
    ep(32'h22334400, 4'b1110, 1'b1);
    send(32'h11223344, 4'b1111, 1'b1, 3'd1);
    repeat (3) @(posedge clk);
    #1;
    eh(32'h00000000, 4'b0000);
    ep(32'h0A0B0C0D, 4'b1111, 1'b1);
    fork
      send(32'h0A0B0C0D, 4'b1111, 1'b1, 3'd0);
      begin
        repeat (3) @(negedge clk);
        chk("hdr_block_ready_in", {63'd0, bus.ready_in}, 64'd0);
        @(posedge clk);
        #1 bus.ready_hdr = 1'b1;
        @(posedge clk);
        #1 pop_cyc = cyc;
      end
    join
    chk("accept_after_pop", 64'(accept_cyc - pop_cyc), 64'd1);
    drain();
`endif

    // reset in BODY drops the partial packet
    eh(32'h0000E1E2, 4'b0011);
    send(32'hE1E2E3E4, 4'b1111, 1'b0, 3'd2);
    send(32'hF1F2F3F4, 4'b1111, 1'b0, 3'd2);
    reset_check();
    @(posedge clk); #1;

    // N=0 passes through with one beat of delay
    eh(32'h00000000, 4'b0000);
    ep(32'h12345678, 4'b1111, 1'b0);
    ep(32'h9ABCDEF0, 4'b1111, 1'b0);
    ep(32'h13570000, 4'b1100, 1'b1);
    send(32'h12345678, 4'b1111, 1'b0, 3'd0);
    send(32'h9ABCDEF0, 4'b1111, 1'b0, 3'd0);
    send(32'h13570000, 4'b1100, 1'b1, 3'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
